jk_pattern_driver: RTL and testbench
====================================

Name: jk_pattern_driver

Overview:
- Drives a JK flip-flop so that its q output follows a requested LEN-bit pattern.
- For each pattern bit it computes the JK excitation from the expected current state and drives jk for one cycle.
- On the following cycle it checks the flip-flop's q feedback and counts mismatches.
- Used as the stimulus/checking end of the jkflipflop interface for self-checking flip-flop tests and in-system flip-flop exercise.

Parameters:
- LEN, 8, number of pattern bits driven per run (≥1).
- CNT_W, 4, width of the mismatch counter; the counter saturates.
- TOGGLE_MODE, 0, 0 = transitions use set (10) or reset (01); 1 = transitions use toggle (11).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  run request; sampled only in IDLE.
- pattern  input  LEN  target q sequence, bit 0 first; latched on accepted start.
- q_fb  input  1  q output of the driven flip-flop.
- jk  output  2  excitation to the flip-flop; jk[1]=J, jk[0]=K.
- ff_reset  output  1  active-high reset to the driven flip-flop.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse when a run finishes.
- err_count  output  CNT_W  mismatches in the last or current run.
- pass  output  1  registered at DONE: 1 when err_count==0.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; jk=00, ff_reset=0, busy=0, done=0, err_count=0, pass=0, bit index=0, expected q=0. A reset mid-run aborts immediately, with no done pulse.
- All outputs are registered.
- IDLE:
  - start==1 latches pattern, clears err_count and pass, and moves to INIT.
  - start==0 stays in IDLE.
- INIT (1 cycle): ff_reset=1, jk=00, expected q=0; next state INIT_CHK.
- INIT_CHK (1 cycle): ff_reset=0, jk=00. If q_fb!=0, err_count increments (saturating). Next state DRIVE with index=0.
- DRIVE (1 cycle): jk = excitation(expected q -> pattern[index]):
  - 0->0 and 1->1: 00.
  - 0->1: 10, or 11 when TOGGLE_MODE=1.
  - 1->0: 01, or 11 when TOGGLE_MODE=1.
  - Expected q is updated to pattern[index]. Next state CHECK.
- CHECK (1 cycle): jk=00. If q_fb!=pattern[index], err_count increments (saturating at 2^CNT_W-1).
  - index==LEN-1 -> DONE.
  - Otherwise index++ and return to DRIVE.
- DONE (1 cycle): done=1, busy=1, pass=(final err_count==0), jk=00; next state IDLE.
- err_count and pass hold after DONE until the next accepted start.
- Timing, with start accepted at edge 0:
  - INIT occupies cycle 1 and INIT_CHK cycle 2.
  - Bit i is driven in cycle 3+2i and checked in cycle 4+2i.
  - done is high in cycle 3+2·LEN (cycle 19 for LEN=8).
- start while busy: ignored, with no effect on the pattern or run; only the latched pattern is used.
- start held high through DONE: a new run is accepted on the first IDLE cycle.
- Mismatch counting and the jk decision are independent: jk is always computed from the expected state, never from q_fb.

Test Plan:
- Ideal JK model, pattern=8'b10110010, TOGGLE_MODE=0, start for one cycle -> jk per bit: 00,10,01,00,10,00,01,10. done in cycle 19; err_count=0; pass=1.
- Same pattern with TOGGLE_MODE=1 -> jk per bit: 00,11,11,00,11,00,11,11. err_count=0; pass=1.
- Flip-flop q stuck at 0, pattern=8'b10110010 -> err_count=4, pass=0.
- CNT_W=2, q stuck at 1, pattern=8'h00 -> 9 raw mismatches (INIT_CHK plus 8 bits); err_count saturates at 3, pass=0.
- Pulse start again in cycle 7 of a run with a different pattern -> the run is unaffected, the jk sequence matches the first pattern, and done comes in cycle 19.
- Drive reset low in cycle 8 of a run -> on the next edge all outputs are zero and the state is IDLE, with no done pulse. A following start runs a full clean run.

Source files
------------

// File: rtl/jk_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_pattern_driver
// Description : Walks a JK flip-flop through a latched LEN-bit q pattern and
//               counts q_fb mismatches against the expected sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_pattern_driver #(
    parameter int LEN         = 8,
    parameter int CNT_W       = 4,
    parameter bit TOGGLE_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN-1:0]   pattern,
    input  logic             q_fb,
    output logic [1:0]       jk,
    output logic             ff_reset,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic             pass
);

    localparam int               IDX_W      = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_INIT_CHK = 3'd2,
        S_DRIVE    = 3'd3,
        S_CHECK    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN-1:0]   r_pat, w_pat_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_exp_q, w_exp_q_nxt;
    logic [1:0]       r_jk, w_jk_nxt;
    logic             r_ff_reset, w_ff_reset_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_err, w_err_nxt;
    logic             r_pass, w_pass_nxt;

    logic [IDX_W-1:0] w_idx_inc;
    logic [CNT_W-1:0] w_err_inc;
    logic [CNT_W-1:0] w_err_chk;

    // Excitation depends only on the expected state, never on q_fb.
    function automatic logic [1:0] f_excite(input logic cur, input logic tgt);
        if (cur == tgt)
            return 2'b00;
        else if (TOGGLE_MODE)
            return 2'b11;
        else
            return tgt ? 2'b10 : 2'b01;
    endfunction

    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_err_inc = (r_err == c_CNT_MAX) ? r_err : r_err + CNT_W'(1);
    assign w_err_chk = (q_fb != r_pat[r_idx]) ? w_err_inc : r_err;

    always_comb begin
        w_state_nxt    = r_state;
        w_pat_nxt      = r_pat;
        w_idx_nxt      = r_idx;
        w_exp_q_nxt    = r_exp_q;
        w_jk_nxt       = 2'b00;
        w_ff_reset_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_pass_nxt     = r_pass;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_INIT;
                    w_pat_nxt      = pattern;
                    w_idx_nxt      = '0;
                    w_exp_q_nxt    = 1'b0;
                    w_err_nxt      = '0;
                    w_pass_nxt     = 1'b0;
                    w_ff_reset_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_INIT: begin
                w_state_nxt = S_INIT_CHK;
            end
            S_INIT_CHK: begin
                if (q_fb)
                    w_err_nxt = w_err_inc;
                w_state_nxt = S_DRIVE;
                w_idx_nxt   = '0;
                w_jk_nxt    = f_excite(r_exp_q, r_pat[0]);
                w_exp_q_nxt = r_pat[0];
            end
            S_DRIVE: begin
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_err_nxt = w_err_chk;
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_chk == '0);
                end else begin
                    w_state_nxt = S_DRIVE;
                    w_idx_nxt   = w_idx_inc;
                    w_jk_nxt    = f_excite(r_exp_q, r_pat[w_idx_inc]);
                    w_exp_q_nxt = r_pat[w_idx_inc];
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pat      <= '0;
            r_idx      <= '0;
            r_exp_q    <= 1'b0;
            r_jk       <= 2'b00;
            r_ff_reset <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pat      <= w_pat_nxt;
            r_idx      <= w_idx_nxt;
            r_exp_q    <= w_exp_q_nxt;
            r_jk       <= w_jk_nxt;
            r_ff_reset <= w_ff_reset_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    assign jk        = r_jk;
    assign ff_reset  = r_ff_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err;
    assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_jk_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_pattern_driver
// Description : Self-checking bench; two driver variants (set/reset, toggle
//               with 2-bit counter) each exercising a behavioural JK flop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_pattern_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    int         mode;   // 0 ideal, 1 q stuck 0, 2 q stuck 1, 3 q inverted

    logic [1:0] jk0, jk1;
    logic       ff_reset0, ff_reset1, busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] err0;
    logic [1:0] err1;
    logic       q0 = 1'b0, q1 = 1'b0;
    logic       qfb0, qfb1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_pattern_driver #(.LEN(8), .CNT_W(4), .TOGGLE_MODE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(qfb0),
        .jk(jk0), .ff_reset(ff_reset0), .busy(busy0), .done(done0),
        .err_count(err0), .pass(pass0)
    );

    jk_pattern_driver #(.LEN(8), .CNT_W(2), .TOGGLE_MODE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(qfb1),
        .jk(jk1), .ff_reset(ff_reset1), .busy(busy1), .done(done1),
        .err_count(err1), .pass(pass1)
    );

    // Behavioural JK flip-flops with synchronous active-high reset
    always @(posedge clk) begin
        if (ff_reset0) q0 <= 1'b0;
        else case (jk0)
            2'b01: q0 <= 1'b0;
            2'b10: q0 <= 1'b1;
            2'b11: q0 <= ~q0;
            default: q0 <= q0;
        endcase
        if (ff_reset1) q1 <= 1'b0;
        else case (jk1)
            2'b01: q1 <= 1'b0;
            2'b10: q1 <= 1'b1;
            2'b11: q1 <= ~q1;
            default: q1 <= q1;
        endcase
    end

    assign qfb0 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (mode == 3) ? ~q0 : q0;
    assign qfb1 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (mode == 3) ? ~q1 : q1;

    // Raw mismatch count: one q check after flop reset (expects 0) plus one per bit.
    function automatic int raw_mismatches(input logic [7:0] pat, input int m);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m == 1 && pat[i] != 1'b0) n++;
            if (m == 2 && pat[i] != 1'b1) n++;
            if (m == 3) n++;
        end
        if (m == 2 || m == 3) n++;
        return n;
    endfunction

    task automatic run_checked(input logic [7:0] pat, input bit pre_started,
                               input bit keep_start, input bit pulse7);
        logic [1:0] ej0 [8];
        logic [1:0] ej1 [8];
        logic [1:0] x0, x1;
        logic [5:0] xc;
        logic       prev;
        int         raw, e0, e1;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pat[i] == prev) begin
                ej0[i] = 2'b00;
                ej1[i] = 2'b00;
            end else begin
                ej0[i] = pat[i] ? 2'b10 : 2'b01;
                ej1[i] = 2'b11;
            end
            prev = pat[i];
        end
        raw = raw_mismatches(pat, mode);
        e0  = (raw > 15) ? 15 : raw;
        e1  = (raw > 3) ? 3 : raw;

        @(negedge clk);
        checks++;
        if ({busy0, busy1, done0, done1} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_before_run: got busy/done=%b expected 0000", {busy0, busy1, done0, done1});
        end
        if (!pre_started) begin
            pattern = pat;
            start   = 1'b1;
        end

        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1 && !keep_start) start = 1'b0;
            if (pulse7 && c == 7) begin
                start   = 1'b1;
                pattern = ~pat;
            end
            if (pulse7 && c == 8) start = 1'b0;

            x0 = 2'b00;
            x1 = 2'b00;
            if (c >= 3 && c <= 17 && (c % 2) == 1) begin
                x0 = ej0[(c - 3) / 2];
                x1 = ej1[(c - 3) / 2];
            end
            checks++;
            if ({jk0, jk1} !== {x0, x1}) begin
                errors++;
                $display("FAIL jk_cycle%0d pat=%h: got %b/%b expected %b/%b", c, pat, jk0, jk1, x0, x1);
            end
            xc = {c == 19, c == 19, 1'b1, 1'b1, c == 1, c == 1};
            checks++;
            if ({done0, done1, busy0, busy1, ff_reset0, ff_reset1} !== xc) begin
                errors++;
                $display("FAIL ctl_cycle%0d pat=%h: got done/busy/ffrst=%b expected %b", c, pat,
                         {done0, done1, busy0, busy1, ff_reset0, ff_reset1}, xc);
            end
            if (c == 1) begin
                checks++;
                if ({err0, err1, pass0, pass1} !== 8'h00) begin
                    errors++;
                    $display("FAIL cleared_on_start: got err/pass=%b expected 0", {err0, err1, pass0, pass1});
                end
            end
        end

        checks++;
        if (err0 !== 4'(e0) || pass0 !== (e0 == 0)) begin
            errors++;
            $display("FAIL result0 pat=%h mode=%0d: got err=%0d pass=%b expected err=%0d pass=%b",
                     pat, mode, err0, pass0, e0, (e0 == 0));
        end
        checks++;
        if (err1 !== 2'(e1) || pass1 !== (e1 == 0)) begin
            errors++;
            $display("FAIL result1 pat=%h mode=%0d: got err=%0d pass=%b expected err=%0d pass=%b",
                     pat, mode, err1, pass1, e1, (e1 == 0));
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start   = 1'b0;
        pattern = 8'h00;
        mode    = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({jk0, ff_reset0, busy0, done0, err0, pass0, jk1, ff_reset1, busy1, done1, err1, pass1} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got %b expected all zero",
                     {jk0, ff_reset0, busy0, done0, err0, pass0, jk1, ff_reset1, busy1, done1, err1, pass1});
        end
        reset = 1'b1;
    endtask

    task automatic test_ideal();
        mode = 0;
        run_checked(8'b10110010, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) run_checked(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_faults();
        mode = 1;
        run_checked(8'b10110010, 1'b0, 1'b0, 1'b0);
        mode = 2;
        run_checked(8'h00, 1'b0, 1'b0, 1'b0);
        mode = 3;
        run_checked(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            mode = int'($urandom_range(0, 3));
            run_checked(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_start_while_busy();
        mode = 0;
        run_checked(8'b01101001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        mode = 0;
        run_checked(8'b11001010, 1'b0, 1'b1, 1'b0);
        pattern = 8'b00110111;
        run_checked(8'b00110111, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        mode = 0;
        @(negedge clk);
        pattern = 8'hA5;
        start   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 8) reset = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({jk0, ff_reset0, busy0, done0, err0, pass0, jk1, ff_reset1, busy1, done1, err1, pass1} !== 18'd0) begin
            errors++;
            $display("FAIL mid_run_reset: got %b expected all zero",
                     {jk0, ff_reset0, busy0, done0, err0, pass0, jk1, ff_reset1, busy1, done1, err1, pass1});
        end
        reset = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if ({done0, done1, busy0, busy1} !== 4'b0000) begin
                errors++;
                $display("FAIL no_done_after_abort: got done/busy=%b expected 0000", {done0, done1, busy0, busy1});
            end
        end
        run_checked(8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_faults();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
